// File: rtl/vga_timing_gen.sv
// 640x480@60 display timing generator: waits for a stable PLL lock, then free-runs
// x/y counters with registered sync/enable decode. Optional VGA_FETCH_EN adds a lead-ahead fetch pair.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int LOCK_WAIT = 16
`ifdef VGA_FETCH_EN
  ,
  parameter int FETCH_LEAD = 2
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic       line_end,
  output logic       running
`ifdef VGA_FETCH_EN
  ,
  output logic [9:0] fetch_x,
  output logic [9:0] fetch_y,
  output logic       fetch_de
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON  = 1'(HSYNC_POL);
  localparam logic HS_OFF = ~HS_ON;
  localparam logic VS_ON  = 1'(VSYNC_POL);
  localparam logic VS_OFF = ~VS_ON;

  localparam int            LCW       = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_WAIT - 1);

  typedef enum logic {
    S_WAIT_LOCK = 1'b0,
    S_RUN       = 1'b1
  } state_t;

  state_t         state_reg, state_next;
  logic [LCW-1:0] lock_cnt_reg, lock_cnt_next;

  logic [9:0] x_next, y_next;
  logic       hsync_next, vsync_next, de_next;
  logic       frame_start_next, line_end_next, running_next;

  function automatic logic [9:0] step_x(input logic [9:0] cx);
    return (cx == H_LAST) ? 10'd0 : cx + 10'd1;
  endfunction

  function automatic logic [9:0] step_y(input logic [9:0] cx, input logic [9:0] cy);
    if (cx != H_LAST) return cy;
    return (cy == V_LAST) ? 10'd0 : cy + 10'd1;
  endfunction

  // State and every output are registered together so x/y and their decodes never skew.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_WAIT_LOCK;
      lock_cnt_reg <= '0;
      x            <= '0;
      y            <= '0;
      de           <= 1'b0;
      hsync        <= HS_OFF;
      vsync        <= VS_OFF;
      frame_start  <= 1'b0;
      line_end     <= 1'b0;
      running      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lock_cnt_reg <= lock_cnt_next;
      x            <= x_next;
      y            <= y_next;
      de           <= de_next;
      hsync        <= hsync_next;
      vsync        <= vsync_next;
      frame_start  <= frame_start_next;
      line_end     <= line_end_next;
      running      <= running_next;
    end
  end

  // Any low sample of pll_locked restarts the qualification count.
  always_comb begin
    state_next    = state_reg;
    lock_cnt_next = '0;
    case (state_reg)
      S_WAIT_LOCK: begin
        if (pll_locked) begin
          if (lock_cnt_reg == LOCK_LAST) begin
            state_next = S_RUN;
          end else begin
            lock_cnt_next = lock_cnt_reg + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!pll_locked) state_next = S_WAIT_LOCK;
      end
      default: state_next = S_WAIT_LOCK;
    endcase
  end

  // Outputs decode the counter values they will be presented alongside.
  always_comb begin
    x_next = '0;
    y_next = '0;
    if (state_next == S_RUN && state_reg == S_RUN) begin
      x_next = step_x(x);
      y_next = step_y(x, y);
    end
    running_next     = (state_next == S_RUN);
    de_next          = running_next && (x_next < H_ACT) && (y_next < V_ACT);
    hsync_next       = (running_next && x_next >= HS_START && x_next < HS_END) ? HS_ON : HS_OFF;
    vsync_next       = (running_next && y_next >= VS_START && y_next < VS_END) ? VS_ON : VS_OFF;
    frame_start_next = running_next && (x_next == 10'd0) && (y_next == 10'd0);
    line_end_next    = running_next && (x_next == H_LAST);
  end

`ifdef VGA_FETCH_EN
  localparam logic [9:0] FETCH_X0 = 10'(FETCH_LEAD);

  logic [9:0] fetch_x_next, fetch_y_next;
  logic       fetch_de_next;

  always_comb begin
    fetch_x_next = '0;
    fetch_y_next = '0;
    if (state_next == S_RUN) begin
      if (state_reg == S_RUN) begin
        fetch_x_next = step_x(fetch_x);
        fetch_y_next = step_y(fetch_x, fetch_y);
      end else begin
        fetch_x_next = FETCH_X0;
      end
    end
    fetch_de_next = (state_next == S_RUN) && (fetch_x_next < H_ACT) && (fetch_y_next < V_ACT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_x  <= '0;
      fetch_y  <= '0;
      fetch_de <= 1'b0;
    end else begin
      fetch_x  <= fetch_x_next;
      fetch_y  <= fetch_y_next;
      fetch_de <= fetch_de_next;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a reduced-geometry instance for whole-frame checks
// alongside a default-geometry instance for real 640x480 line timing.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;

  logic       s_hsync, s_vsync, s_de, s_fs, s_le, s_run;
  logic [9:0] s_x, s_y;
  logic       d_hsync, d_vsync, d_de, d_fs, d_le, d_run;
  logic [9:0] d_x, d_y;
`ifdef VGA_FETCH_EN
  logic [9:0] s_fx, s_fy, d_fx, d_fy;
  logic       s_fde, d_fde;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Small geometry: H 16+4+6+6 = 32, V 8+2+2+3 = 15, frame = 480 cycles.
`ifdef VGA_FETCH_EN
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .FETCH_LEAD(2)
  ) dut_s (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .hsync(s_hsync), .vsync(s_vsync), .de(s_de), .x(s_x), .y(s_y),
    .frame_start(s_fs), .line_end(s_le), .running(s_run),
    .fetch_x(s_fx), .fetch_y(s_fy), .fetch_de(s_fde)
  );
  vga_timing_gen dut_d (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .hsync(d_hsync), .vsync(d_vsync), .de(d_de), .x(d_x), .y(d_y),
    .frame_start(d_fs), .line_end(d_le), .running(d_run),
    .fetch_x(d_fx), .fetch_y(d_fy), .fetch_de(d_fde)
  );
`else
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_s (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .hsync(s_hsync), .vsync(s_vsync), .de(s_de), .x(s_x), .y(s_y),
    .frame_start(s_fs), .line_end(s_le), .running(s_run)
  );
  vga_timing_gen dut_d (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .hsync(d_hsync), .vsync(d_vsync), .de(d_de), .x(d_x), .y(d_y),
    .frame_start(d_fs), .line_end(d_le), .running(d_run)
  );
`endif

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_run"}, int'(s_run), 0);
    chk({tag, "_x"}, int'(s_x), 0);
    chk({tag, "_y"}, int'(s_y), 0);
    chk({tag, "_de"}, int'(s_de), 0);
    chk({tag, "_hs"}, int'(s_hsync), 1);
    chk({tag, "_vs"}, int'(s_vsync), 1);
    chk({tag, "_fs"}, int'(s_fs), 0);
    chk({tag, "_le"}, int'(s_le), 0);
    chk({tag, "_d_run"}, int'(d_run), 0);
    chk({tag, "_d_x"}, int'(d_x), 0);
    chk({tag, "_d_hs"}, int'(d_hsync), 1);
`ifdef VGA_FETCH_EN
    chk({tag, "_fx"}, int'(s_fx), 0);
    chk({tag, "_fy"}, int'(s_fy), 0);
    chk({tag, "_fde"}, int'(s_fde), 0);
`endif
  endtask

  // Expects 15 edges without running, then the first RUN cycle on the 16th locked edge.
  task automatic wait_lock_16(input string tag);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk({tag, "_pre_run"}, int'(s_run), 0);
      chk({tag, "_pre_x"}, int'(s_x), 0);
    end
    tick();
    chk({tag, "_run"}, int'(s_run), 1);
    chk({tag, "_x0"}, int'(s_x), 0);
    chk({tag, "_y0"}, int'(s_y), 0);
    chk({tag, "_de0"}, int'(s_de), 1);
    chk({tag, "_fs0"}, int'(s_fs), 1);
    chk({tag, "_le0"}, int'(s_le), 0);
    chk({tag, "_d_run"}, int'(d_run), 1);
    chk({tag, "_d_fs0"}, int'(d_fs), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int sx, sy, dx, dy;

    // Reset values while rst is held.
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    $display("txn reset: idle outputs checked");

    // Constant lock after reset.
    pll_locked = 1'b1;
    wait_lock_16("lock");
    $display("txn lock: running after 16 locked edges");

    // Full small frame plus wrap; default instance covers the first 900 cycles of 640x480.
    for (int n = 0; n < 900; n++) begin
      sx = n % 32;
      sy = (n / 32) % 15;
      chk("s_x", int'(s_x), sx);
      chk("s_y", int'(s_y), sy);
      chk("s_de", int'(s_de), (sx < 16 && sy < 8) ? 1 : 0);
      chk("s_hs", int'(s_hsync), (sx >= 20 && sx < 26) ? 0 : 1);
      chk("s_vs", int'(s_vsync), (sy >= 10 && sy < 12) ? 0 : 1);
      chk("s_fs", int'(s_fs), (sx == 0 && sy == 0) ? 1 : 0);
      chk("s_le", int'(s_le), (sx == 31) ? 1 : 0);
      chk("s_run", int'(s_run), 1);
`ifdef VGA_FETCH_EN
      chk("s_fx", int'(s_fx), (n + 2) % 32);
      chk("s_fy", int'(s_fy), ((n + 2) / 32) % 15);
      chk("s_fde", int'(s_fde), (((n + 2) % 32) < 16 && (((n + 2) / 32) % 15) < 8) ? 1 : 0);
`endif
      dx = n % 800;
      dy = n / 800;
      chk("d_x", int'(d_x), dx);
      chk("d_y", int'(d_y), dy);
      chk("d_de", int'(d_de), (dx < 640) ? 1 : 0);
      chk("d_hs", int'(d_hsync), (dx >= 656 && dx < 752) ? 0 : 1);
      chk("d_vs", int'(d_vsync), 1);
      chk("d_le", int'(d_le), (dx == 799) ? 1 : 0);
      chk("d_fs", int'(d_fs), (n == 0) ? 1 : 0);
      tick();
    end
    $display("txn frame: 900 cycles of counter and decode checked");

    // Drop lock mid-frame at x=20, y=5 of the small instance.
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (s_x == 10'd20 && s_y == 10'd5) found = 1'b1;
      else tick();
    end
    chk("find_drop_point", int'(found), 1);
    pll_locked = 1'b0;
    tick();
    check_idle("drop");
    pll_locked = 1'b1;
    wait_lock_16("relock");
    $display("txn lock loss: idle next edge, restart at origin");

    // Asynchronous reset between edges.
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    check_idle("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("txn async reset: outputs idle before next edge");

    // Lock glitch: 10 good edges, 1 bad, then count restarts.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_pre_run", int'(s_run), 0);
    end
    pll_locked = 1'b0;
    tick();
    chk("glitch_low_run", int'(s_run), 0);
    pll_locked = 1'b1;
    wait_lock_16("glitch");
    $display("txn glitch: lock count restarted after low sample");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
